// File: rtl/gate_pkg.sv
// gate_pkg: mode encodings, sequencer state type and gate_ref expected-bit helper
package gate_pkg;
  localparam int unsigned MODE_OR = 0;
  localparam int unsigned MODE_AND = 1;
  localparam int unsigned MODE_XOR = 2;
  localparam int unsigned MODE_XNOR = 3;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic logic gate_ref(input int unsigned m, input logic a, input logic b);
    return m == MODE_OR ? a | b : m == MODE_AND ? a & b : m == MODE_XOR ? a ^ b : ~(a ^ b);
  endfunction
endpackage

// File: rtl/gate_op_sequencer_if.sv
// gate_op_sequencer_if: vector bus m/a/b/exp with vld/rdy; master drives vectors, slave returns rdy
interface gate_op_sequencer_if #(parameter int MODE_W = 2);
  logic [MODE_W-1:0] m;
  logic a, b, exp, vld, rdy;
  modport master(output m, a, b, exp, vld, input rdy);
  modport slave(input m, a, b, exp, vld, output rdy);
endinterface

// File: rtl/gate_seq_idx_ctr.sv
// gate_seq_idx_ctr: nested mode (inner) / operand index (outer) counter with clr, adv, next-value and wrap outputs
module gate_seq_idx_ctr #(
  parameter int MODE_W = 2,
  parameter int OPIDX_W = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               adv,
  output logic [MODE_W-1:0]  m,
  output logic [OPIDX_W-1:0] idx,
  output logic [MODE_W-1:0]  nxt_m,
  output logic [OPIDX_W-1:0] nxt_idx,
  output logic               wrap
);
  logic m_max, i_max;
  assign m_max = &m;
  assign i_max = &idx;
  always_comb begin
    nxt_m = clr ? '0 : adv ? (m_max ? '0 : m + MODE_W'(1)) : m;
    nxt_idx = clr ? '0 : (adv && m_max) ? idx + OPIDX_W'(1) : idx;
    wrap = adv && m_max && i_max;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      m <= '0;
      idx <= '0;
    end else begin
      m <= nxt_m;
      idx <= nxt_idx;
    end
  end
endmodule

// File: rtl/gate_op_sequencer.sv
// gate_op_sequencer: sweeps every (mode,{a,b}) vector over bus (m,a,b,exp,vld / rdy) on start, stop aborts; outputs busy, done pulse, vec_cnt; GATE_SEQ_LOOP_EN repeats sweeps until stop
module gate_op_sequencer
  import gate_pkg::*;
#(
  parameter int MODE_W = 2,
  parameter int OPIDX_W = 2,
  parameter int CNT_W = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  gate_op_sequencer_if.master bus,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    vec_cnt
);
`ifdef GATE_SEQ_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif
  state_t state;
  logic vld_q, exp_q, clr, adv, wrap;
  logic [MODE_W-1:0] m_q, nxt_m;
  logic [OPIDX_W-1:0] idx_q, nxt_idx;
  assign clr = !stop && ((state == IDLE && start) || (state == DONE && LOOP));
  assign adv = state == RUN && vld_q && bus.rdy && !stop;
  gate_seq_idx_ctr #(.MODE_W(MODE_W), .OPIDX_W(OPIDX_W)) u_ctr (
    .clk(clk), .rst(rst), .clr(clr), .adv(adv),
    .m(m_q), .idx(idx_q), .nxt_m(nxt_m), .nxt_idx(nxt_idx), .wrap(wrap)
  );
  assign bus.m = m_q;
  assign bus.a = idx_q[1];
  assign bus.b = idx_q[0];
  assign bus.exp = exp_q;
  assign bus.vld = vld_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      vld_q <= 1'b0;
      exp_q <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      vec_cnt <= '0;
    end else begin
      exp_q <= gate_ref(int'(nxt_m), nxt_idx[1], nxt_idx[0]);
      done <= 1'b0;
      case (state)
        IDLE: if (clr) begin
          state <= RUN;
          vld_q <= 1'b1;
          busy <= 1'b1;
          vec_cnt <= '0;
        end
        RUN: if (stop) begin
          state <= IDLE;
          vld_q <= 1'b0;
          busy <= 1'b0;
        end else if (adv) begin
          vec_cnt <= vec_cnt + CNT_W'(1);
          if (wrap) begin
            state <= DONE;
            vld_q <= 1'b0;
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
        default: begin
          state <= clr ? RUN : IDLE;
          vld_q <= clr;
          busy <= clr;
          if (clr) vec_cnt <= '0;
        end
      endcase
    end
  end
endmodule
